// File: rtl/sha_compress.sv
`default_nettype none
// ============================================================================
// Module   : sha_compress
// Brief    : SHA-256 compression core, one round per clock. Round 0 is fed
//            straight from H_in on the start cycle; digest appears 64 cycles
//            after start together with a one-cycle digest_valid pulse.
// Revision : 1.0  initial release
// ============================================================================
module sha_compress (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  W,
    input  logic [255:0] H_in,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [0:0]   r_state;
    logic [0:0]   w_state_next;
    logic [5:0]   r_round;
    logic [255:0] r_wv;       // working variables {a,b,c,d,e,f,g,h}
    logic [255:0] r_hin;      // chaining value captured on start
    logic [255:0] r_digest;
    logic         r_digest_valid;

    logic [5:0]   w_ridx;
    logic [255:0] w_src;
    logic [255:0] w_next;
    logic [255:0] w_sum;
    logic [31:0]  w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0]  w_bs0, w_bs1, w_ch, w_maj, w_t1, w_t2;

    // Start cycle computes round 0 directly from H_in, bypassing the registers
    assign w_ridx = start ? 6'd0 : r_round;
    assign w_src  = start ? H_in : r_wv;
    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = w_src;

    assign w_bs0 = {w_a[1:0], w_a[31:2]} ^ {w_a[12:0], w_a[31:13]} ^ {w_a[21:0], w_a[31:22]};
    assign w_bs1 = {w_e[5:0], w_e[31:6]} ^ {w_e[10:0], w_e[31:11]} ^ {w_e[24:0], w_e[31:25]};
    assign w_ch  = (w_e & w_f) ^ (~w_e & w_g);
    assign w_maj = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
    assign w_t1  = w_h + w_bs1 + w_ch + c_K[w_ridx] + W;
    assign w_t2  = w_bs0 + w_maj;

    assign w_next = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

    // Final feed-forward: latched chaining value plus the round-63 result, per lane
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign w_sum[32*gi +: 32] = r_hin[32*gi +: 32] + w_next[32*gi +: 32];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start always (re)enters RUN; round 63 completes the block
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (start) w_state_next = S_RUN;
                     else if (r_round == 6'd63) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == S_RUN);
    end

    // Datapath: round registers, counter, chaining latch and digest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wv           <= '0;
            r_hin          <= '0;
            r_round        <= '0;
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            r_digest_valid <= 1'b0;
            if (start) begin
                r_hin   <= H_in;
                r_wv    <= w_next;
                r_round <= 6'd1;
            end else if (r_state == S_RUN) begin
                r_wv <= w_next;
                if (r_round == 6'd63) begin
                    r_digest       <= w_sum;
                    r_digest_valid <= 1'b1;
                    r_round        <= 6'd0;
                end else begin
                    r_round <= r_round + 6'd1;
                end
            end
        end
    end

    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_sha_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_compress
// Brief    : Scoreboard bench for sha_compress using the standard SHA-256
//            test blocks; the driver expands each padded block into W0..W63.
// Revision : 1.0  initial release
// ============================================================================
module tb_sha_compress;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  W;
    logic [255:0] H_in;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;

    int tests;
    int fails;
    int cyc;

    logic [255:0] sb_d[$];
    int           sb_c[$];
    logic [255:0] exp_hold;

    localparam logic [255:0] c_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] c_D_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] c_D_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] c_D_TWO1 =
        256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] c_D_TWO2 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] c_B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] c_B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] c_B_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] c_B_TWO2  = {480'h0, 32'h000001c0};

    sha_compress dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .W            (W),
        .H_in         (H_in),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one padded block starting now; nwords < 64 leaves it abandoned
    task automatic drive_block(input logic [511:0] blk, input logic [255:0] hin,
                               input logic [255:0] exp_d, input int nwords, input bit push);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
        if (push) begin
            sb_d.push_back(exp_d);
            sb_c.push_back(cyc + 64);
        end
        for (int j = 0; j < nwords; j++) begin
            start = (j == 0);
            W     = w[j];
            H_in  = (j == 0) ? hin : ~hin;
            @(posedge clk);
            #1;
            if (j < 63) chk("busy_run", {255'h0, busy}, 256'h1);
        end
        start = 1'b0;
        W     = 32'hdeadbeef;
        H_in  = ~hin;
        if (nwords == 64) chk("busy_done", {255'h0, busy}, 256'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each digest_valid and tracks the held digest
    initial begin
        exp_hold = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) exp_hold = '0;
            if (digest_valid) begin
                if (sb_d.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: digest_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    logic [255:0] ed;
                    int           ec;
                    ed = sb_d.pop_front();
                    ec = sb_c.pop_front();
                    chk("valid_cycle", 256'(cyc), 256'(ec));
                    chk("digest", digest, ed);
                    exp_hold = ed;
                end
            end else begin
                chk("digest_hold", digest, exp_hold);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        start = 1'b0;
        W     = '0;
        H_in  = '0;
        #1 rst_n = 1'b0;
        idle(3);
        chk("reset_busy",  {255'h0, busy}, 256'h0);
        chk("reset_valid", {255'h0, digest_valid}, 256'h0);
        chk("reset_digest", digest, 256'h0);
        rst_n = 1'b1;
        idle(1);

        // Single blocks
        drive_block(c_B_ABC, c_IV, c_D_ABC, 64, 1'b1);
        idle(5);
        drive_block(c_B_EMPTY, c_IV, c_D_EMPTY, 64, 1'b1);
        idle(3);

        // Back-to-back: second start coincides with the first digest_valid
        drive_block(c_B_ABC, c_IV, c_D_ABC, 64, 1'b1);
        drive_block(c_B_EMPTY, c_IV, c_D_EMPTY, 64, 1'b1);
        idle(4);

        // Restart after 20 rounds: only the second block completes
        drive_block(c_B_EMPTY, c_IV, c_D_EMPTY, 20, 1'b0);
        drive_block(c_B_ABC, c_IV, c_D_ABC, 64, 1'b1);
        idle(4);

        // Reset mid-compression, then a fresh block
        drive_block(c_B_ABC, c_IV, c_D_ABC, 30, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {255'h0, busy}, 256'h0);
        chk("midrst_valid",  {255'h0, digest_valid}, 256'h0);
        chk("midrst_digest", digest, 256'h0);
        idle(3);
        rst_n = 1'b1;
        idle(1);
        drive_block(c_B_ABC, c_IV, c_D_ABC, 64, 1'b1);
        idle(2);

        // Two-block message, block 2 chained from block 1
        drive_block(c_B_TWO1, c_IV, c_D_TWO1, 64, 1'b1);
        drive_block(c_B_TWO2, c_D_TWO1, c_D_TWO2, 64, 1'b1);

        // No further activity without start
        idle(100);
        chk("idle_busy", {255'h0, busy}, 256'h0);
        chk("scoreboard_drained", 256'(sb_d.size()), 256'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
